// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multicycle CPU: fetch/decode/execute/memory/writeback
// with a memory ready handshake. Optional andi/ori support under `LOGICAL_IMM_EN.
module multicycle_control (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_source,
   output logic       ext_op,
   output logic       illegal,
   output logic [3:0] state
);

   localparam int unsigned OP_W = 6;
   localparam int unsigned ST_W = 4;

   localparam logic [OP_W-1:0] OP_R    = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_W-1:0] OP_J    = 6'b000010;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
   localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;

`ifdef LOGICAL_IMM_EN
   localparam logic LOGIC_EN = 1'b1;
`else
   localparam logic LOGIC_EN = 1'b0;
`endif

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_FUNCT = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;

   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_OUT  = 2'b01;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;

   typedef enum logic [ST_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11
   } state_t;

   state_t r_state;
   state_t w_next;

   logic       w_is_andi;
   logic       w_is_ori;
   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic       w_ir_write;
   logic       w_reg_write;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_iord;
   logic       w_mem_to_reg;
   logic       w_reg_dst;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [2:0] w_alu_op;
   logic [1:0] w_pc_source;
   logic       w_illegal;
   logic       w_ext_op;

   // Branch resolution happens in the datapath (pc_write_cond & zero).
   logic w_unused_zero;
   assign w_unused_zero = zero;

   assign w_is_andi = LOGIC_EN & (opcode == OP_ANDI);
   assign w_is_ori  = LOGIC_EN & (opcode == OP_ORI);
   assign w_ext_op  = ~(w_is_andi | w_is_ori);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next          = r_state;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_ir_write      = 1'b0;
      w_reg_write     = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_iord          = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_reg_dst       = 1'b0;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = SRCB_REG;
      w_alu_op        = ALU_ADD;
      w_pc_source     = PCSRC_ALU;
      w_illegal       = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = SRCB_FOUR;
            w_ir_write  = mem_ready;
            w_pc_write  = mem_ready;
            if (mem_ready) begin
               w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            w_alu_src_b = SRCB_IMM2;
            if ((opcode == OP_LW) || (opcode == OP_SW)) begin
               w_next = S_MEMADR;
            end else if (opcode == OP_R) begin
               w_next = S_EXEC;
            end else if (opcode == OP_BEQ) begin
               w_next = S_BRANCH;
            end else if (opcode == OP_J) begin
               w_next = S_JUMP;
            end else if ((opcode == OP_ADDI) || w_is_andi || w_is_ori) begin
               w_next = S_IEXEC;
            end else begin
               w_next    = S_FETCH;
               w_illegal = 1'b1;
            end
         end
         S_MEMADR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_IMM;
            w_next      = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            w_iord     = 1'b1;
            w_mem_read = 1'b1;
            if (mem_ready) begin
               w_next = S_MEMWB;
            end
         end
         S_MEMWB: begin
            w_reg_write  = 1'b1;
            w_mem_to_reg = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEMWR: begin
            w_iord      = 1'b1;
            w_mem_write = 1'b1;
            if (mem_ready) begin
               w_next = S_FETCH;
            end
         end
         S_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = ALU_FUNCT;
            w_next      = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write = 1'b1;
            w_reg_dst   = 1'b1;
            w_next      = S_FETCH;
         end
         S_BRANCH: begin
            w_alu_src_a     = 1'b1;
            w_alu_op        = ALU_SUB;
            w_pc_write_cond = 1'b1;
            w_pc_source     = PCSRC_OUT;
            w_next          = S_FETCH;
         end
         S_JUMP: begin
            w_pc_write  = 1'b1;
            w_pc_source = PCSRC_JUMP;
            w_next      = S_FETCH;
         end
         S_IEXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = SRCB_IMM;
            if (w_is_andi) begin
               w_alu_op = ALU_AND;
            end else if (w_is_ori) begin
               w_alu_op = ALU_OR;
            end
            w_next = S_IWB;
         end
         S_IWB: begin
            w_reg_write = 1'b1;
            w_next      = S_FETCH;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   // Hold every output quiet while reset is asserted, regardless of opcode or mem_ready.
   assign pc_write      = reset_n & w_pc_write;
   assign pc_write_cond = reset_n & w_pc_write_cond;
   assign ir_write      = reset_n & w_ir_write;
   assign reg_write     = reset_n & w_reg_write;
   assign mem_read      = reset_n & w_mem_read;
   assign mem_write     = reset_n & w_mem_write;
   assign iord          = reset_n & w_iord;
   assign mem_to_reg    = reset_n & w_mem_to_reg;
   assign reg_dst       = reset_n & w_reg_dst;
   assign alu_src_a     = reset_n & w_alu_src_a;
   assign alu_src_b     = reset_n ? w_alu_src_b : SRCB_REG;
   assign alu_op        = reset_n ? w_alu_op : ALU_ADD;
   assign pc_source     = reset_n ? w_pc_source : PCSRC_ALU;
   assign illegal       = reset_n & w_illegal;
   assign ext_op        = ~reset_n | w_ext_op;
   assign state         = ST_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state and control
// word are queued at stimulus time and compared by a monitor mid-cycle.
module tb_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_BAD  = 6'b111111;

`ifdef LOGICAL_IMM_EN
   localparam bit LOGIC_EN = 1'b1;
`else
   localparam bit LOGIC_EN = 1'b0;
`endif

   logic       clk;
   logic       reset_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
   logic       iord, mem_to_reg, reg_dst, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic [1:0] pc_source;
   logic       ext_op;
   logic       illegal;
   logic [3:0] state;

   multicycle_control dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .opcode        (opcode),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .ir_write      (ir_write),
      .reg_write     (reg_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .iord          (iord),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .pc_source     (pc_source),
      .ext_op        (ext_op),
      .illegal       (illegal),
      .state         (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [18:0] obs;
   assign obs = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
                 iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_op, pc_source,
                 ext_op, illegal};

   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic [18:0] ctl;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit legal_op(input logic [5:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_J) || (op == OP_ADDI) ||
             (LOGIC_EN && ((op == OP_ANDI) || (op == OP_ORI)));
   endfunction

   // Expected control word per state, written straight from the state table.
   function automatic logic [18:0] spec_ctl(input logic [3:0] st, input logic [5:0] op,
                                            input logic mr, input logic rn);
      logic pcw, pcwc, irw, rw, mrd, mw, io, m2r, rd, asa, ext, ill;
      logic [1:0] asb, psrc;
      logic [2:0] aop;
      {pcw, pcwc, irw, rw, mrd, mw, io, m2r, rd, asa, ill} = '0;
      asb  = 2'b00;
      psrc = 2'b00;
      aop  = 3'b000;
      ext  = !(LOGIC_EN && ((op == OP_ANDI) || (op == OP_ORI)));
      if (!rn) begin
         ext = 1'b1;
      end else begin
         case (st)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin asb = 2'b11; ill = !legal_op(op); end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin io = 1; mrd = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin asa = 1; aop = 3'b010; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 3'b001; pcwc = 1; psrc = 2'b01; end
            4'd9:  begin pcw = 1; psrc = 2'b10; end
            4'd10: begin
               asa = 1; asb = 2'b10;
               if (op == OP_ANDI) aop = 3'b011;
               else if (op == OP_ORI) aop = 3'b100;
            end
            4'd11: begin rw = 1; end
            default: ;
         endcase
      end
      return {pcw, pcwc, irw, rw, mrd, mw, io, m2r, rd, asa, asb, aop, psrc, ext, ill};
   endfunction

   // One cycle of stimulus: drive inputs at negedge and queue what this cycle must show.
   task automatic cyc(input string tag, input logic rn, input logic [5:0] op,
                      input logic mr, input logic [3:0] st);
      exp_t e;
      @(negedge clk);
      reset_n   = rn;
      opcode    = op;
      mem_ready = mr;
      e.tag = tag;
      e.st  = st;
      e.ctl = spec_ctl(st, op, mr, rn);
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check_val({e.tag, ".state"}, 32'(state), 32'(e.st));
         check_val({e.tag, ".ctl"}, 32'(obs), 32'(e.ctl));
      end
   end

   initial begin
      reset_n   = 1'b0;
      opcode    = OP_LW;
      zero      = 1'b0;
      mem_ready = 1'b1;

      cyc("rst0", 0, OP_LW, 1, 0);
      cyc("rst1", 0, OP_ANDI, 1, 0);

      // lw, memory always ready: 5 cycles
      cyc("lw_f",  1, OP_LW, 1, 0);
      cyc("lw_d",  1, OP_LW, 1, 1);
      cyc("lw_a",  1, OP_LW, 1, 2);
      cyc("lw_r",  1, OP_LW, 1, 3);
      cyc("lw_wb", 1, OP_LW, 1, 4);

      // sw with 3 wait cycles in MEMWR: 7 cycles
      cyc("sw_f",  1, OP_SW, 1, 0);
      cyc("sw_d",  1, OP_SW, 0, 1);
      cyc("sw_a",  1, OP_SW, 0, 2);
      cyc("sw_w0", 1, OP_SW, 0, 5);
      cyc("sw_w1", 1, OP_SW, 0, 5);
      cyc("sw_w2", 1, OP_SW, 0, 5);
      cyc("sw_w3", 1, OP_SW, 1, 5);

      // R-type, mem_ready low where it must be ignored
      cyc("r_f",  1, OP_R, 1, 0);
      cyc("r_d",  1, OP_R, 0, 1);
      cyc("r_x",  1, OP_R, 0, 6);
      cyc("r_wb", 1, OP_R, 0, 7);

      cyc("addi_f",  1, OP_ADDI, 1, 0);
      cyc("addi_d",  1, OP_ADDI, 1, 1);
      cyc("addi_x",  1, OP_ADDI, 1, 10);
      cyc("addi_wb", 1, OP_ADDI, 1, 11);

      cyc("ori_f", 1, OP_ORI, 1, 0);
      cyc("ori_d", 1, OP_ORI, 1, 1);
      if (LOGIC_EN) begin
         cyc("ori_x",  1, OP_ORI, 1, 10);
         cyc("ori_wb", 1, OP_ORI, 1, 11);
      end

      cyc("andi_f", 1, OP_ANDI, 1, 0);
      cyc("andi_d", 1, OP_ANDI, 1, 1);
      if (LOGIC_EN) begin
         cyc("andi_x",  1, OP_ANDI, 1, 10);
         cyc("andi_wb", 1, OP_ANDI, 1, 11);
      end

      cyc("beq_f", 1, OP_BEQ, 1, 0);
      cyc("beq_d", 1, OP_BEQ, 1, 1);
      cyc("beq_b", 1, OP_BEQ, 1, 8);

      cyc("bad_f", 1, OP_BAD, 1, 0);
      cyc("bad_d", 1, OP_BAD, 1, 1);

      // j with two stalled fetch cycles
      cyc("j_f0", 1, OP_J, 0, 0);
      cyc("j_f1", 1, OP_J, 0, 0);
      cyc("j_f2", 1, OP_J, 1, 0);
      cyc("j_d",  1, OP_J, 1, 1);
      cyc("j_j",  1, OP_J, 1, 9);

      // lw aborted by reset while stalled in MEMRD
      cyc("lwx_f",  1, OP_LW, 1, 0);
      cyc("lwx_d",  1, OP_LW, 1, 1);
      cyc("lwx_a",  1, OP_LW, 1, 2);
      cyc("lwx_r",  1, OP_LW, 0, 3);
      cyc("lwx_rst", 0, OP_LW, 1, 0);
      cyc("lwx_f2", 1, OP_LW, 1, 0);
      cyc("lwx_d2", 1, OP_LW, 1, 1);
      cyc("lwx_a2", 1, OP_LW, 1, 2);
      cyc("lwx_r2", 1, OP_LW, 1, 3);
      cyc("lwx_wb", 1, OP_LW, 1, 4);
      cyc("end_f",  1, OP_R, 0, 0);

      @(negedge clk);
      #5;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM for the multicycle CPU datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and waits on memory through a ready handshake. It drives every datapath mux select and write enable, including `ext_op`, which selects between the zero extender and the sign extender on the immediate path. It sits beside the datapath and sees only the IR opcode, the ALU zero flag and memory ready.

## Interface
- no parameters
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  IR[31:26]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_read`, `mem_write`  out  1 each  enables
- `iord`, `mem_to_reg`, `reg_dst`, `alu_src_a`  out  1 each  mux selects
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
- `alu_op`  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or
- `pc_source`  out  2  00 ALU, 01 ALUOut, 10 jump target
- `ext_op`  out  1  1 sign-extend, 0 zero-extend
- `illegal`  out  1  one-cycle pulse on an unknown opcode
- `state`  out  4  current state, for debug

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11.
- Outputs are Moore from `state`, except where gated by `mem_ready` or `zero`. Any output not listed for a state is 0.
- **FETCH**
  - `mem_read`=1, `alu_src_b`=01, `alu_op`=000.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Go to DECODE when `mem_ready`, otherwise hold in FETCH.
- **DECODE**
  - `alu_src_b`=11, `alu_op`=000 (branch target).
  - Next state: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi/andi/ori→IEXEC.
  - Any other opcode→FETCH, with `illegal`=1 for that cycle.
- **MEMADR**
  - `alu_src_a`=1, `alu_src_b`=10, `alu_op`=000.
  - lw→MEMRD, sw→MEMWR.
- **MEMRD**
  - `iord`=1, `mem_read`=1.
  - Hold until `mem_ready`, then go to MEMWB.
- **MEMWB**
  - `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - Go to FETCH.
- **MEMWR**
  - `iord`=1, `mem_write`=1.
  - Hold until `mem_ready`, then go to FETCH.
  - `mem_write` stays asserted for every cycle the state is held.
- **EXEC**
  - `alu_src_a`=1, `alu_src_b`=00, `alu_op`=010.
  - Go to ALUWB.
- **ALUWB**
  - `reg_write`=1, `reg_dst`=1.
  - Go to FETCH.
- **BRANCH**
  - `alu_src_a`=1, `alu_src_b`=00, `alu_op`=001, `pc_write_cond`=1, `pc_source`=01.
  - Go to FETCH.
- **JUMP**
  - `pc_write`=1, `pc_source`=10.
  - Go to FETCH.
- **IEXEC**
  - `alu_src_a`=1, `alu_src_b`=10.
  - `alu_op`: 000 for addi, 011 for andi, 100 for ori.
  - Go to IWB.
- **IWB**
  - `reg_write`=1, `reg_dst`=0.
  - Go to FETCH.
- `ext_op` is combinational from `opcode` in every state: 0 for andi/ori, 1 otherwise.
- `pc_write_cond` is raw. The datapath ANDs it with `zero`; this block does not look at `zero`.

## Timing
- `reset_n` low asynchronously forces `state`=FETCH.
- While `reset_n` is low, all outputs are 0 except `ext_op`=1. Releasing reset starts FETCH on the next edge.
- Reset mid-instruction aborts the instruction. No write enable may glitch high during reset.
- Cycle counts with `mem_ready` held high:
  - lw 5; sw 4; R 4; addi/andi/ori 4; beq 3; j 3.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR, and ignored in all other states.
- `illegal` is high for exactly the one DECODE cycle; no write enable fires for that instruction.

## Configuration
- `LOGICAL_IMM_EN` defined:
  - andi/ori decode to IEXEC as above.
  - `ext_op`=0 for those opcodes.
- `LOGICAL_IMM_EN` undefined:
  - andi/ori are treated as illegal (DECODE→FETCH, `illegal` pulses).
  - `ext_op` is constant 1.
  - `alu_op` codes 011 and 100 are never produced.

## Test plan
- Reset release with `mem_ready`=1, opcode 100011 (lw): `state` follows 0,1,2,3,4,0. `reg_write`=1 and `mem_to_reg`=1 only in cycle 5.
- sw with `mem_ready` low for 3 cycles in MEMWR: `mem_write` stays high 4 cycles, then `state`=0; total 7 cycles.
- ori (001101) with the macro defined: `ext_op`=0 throughout, IEXEC gives `alu_op`=100 and `alu_src_b`=10, IWB gives `reg_write`=1. Without the macro: `illegal` pulses in DECODE and the next state is 0.
- beq: BRANCH gives `pc_write_cond`=1, `pc_source`=01, `alu_op`=001. DECODE gives `ext_op`=1 and `alu_src_b`=11.
- Opcode 111111: `illegal`=1 for one cycle and no enable asserted. Then j (000010): `pc_write`=1 with `pc_source`=10.
- `reset_n` pulsed low during MEMRD: all enables 0 at once and `ext_op`=1. After release, `state`=0.
